// File: rtl/u_seq_bam_pkg.sv
// bam_pkg: shared state type, width limits and column-mask helper
// for the sequential broken-array multiplier.
package bam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } bam_state_t;

    // Widest operand the mask helper can describe, and the matching product width.
    localparam int MAX_N  = 32;
    localparam int MAX_PW = 2 * MAX_N;

    // Column j of row r is kept when its weight r+j reaches the vertical break v.
    function automatic logic [MAX_N-1:0] bam_row_mask(
        input int unsigned r,
        input int unsigned v,
        input int unsigned n
    );
        logic [MAX_N-1:0] m;
        m = '0;
        for (int unsigned j = 0; j < MAX_N; j++) begin
            m[j] = (j < n) && ((r + j) >= v);
        end
        return m;
    endfunction

endpackage

// File: rtl/u_seq_bam_if.sv
// Operand/result handshake bundle for u_seq_bam.
// master drives operations and consumes results; slave is the multiplier.
interface u_seq_bam_if #(
    parameter int N  = 8,
    parameter int HW = $clog2(N + 1),
    parameter int VW = $clog2(2 * N + 1)
) ();

    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [HW-1:0]  h;
    logic [VW-1:0]  v;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_p;

    modport master (
        output in_valid,
        output a,
        output b,
        output h,
        output v,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_p
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  h,
        input  v,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_p
    );

endinterface

// File: rtl/u_seq_bam_row_gen.sv
// bam_row_gen: one retained partial-product row, masked by the
// vertical break and shifted to its weight.
module bam_row_gen
    import bam_pkg::*;
#(
    parameter int N  = 8,
    parameter int HW = $clog2(N + 1),
    parameter int VW = $clog2(2 * N + 1)
) (
    input  logic [N-1:0]   a,
    input  logic           b_bit,
    input  logic [HW-1:0]  r,
    input  logic [VW-1:0]  v,
    output logic [2*N-1:0] row
);

    localparam int PW = 2 * N;

    logic [N-1:0] am;

    assign am  = N'(MAX_N'(a) & bam_row_mask(32'(r), 32'(v), 32'(N)));
    assign row = b_bit ? (PW'(am) << r) : '0;

endmodule

// File: rtl/u_seq_bam.sv
// u_seq_bam: sequential broken-array multiplier, one retained row per
// cycle, with runtime horizontal (h) and vertical (v) break levels.
module u_seq_bam
    import bam_pkg::*;
#(
    parameter int N  = 8,
    parameter int HW = $clog2(N + 1),
    parameter int VW = $clog2(2 * N + 1)
) (
    input logic        clk,
    input logic        rst_n,
    u_seq_bam_if.slave bus
);

    localparam logic [HW-1:0] N_H  = HW'(N);
    localparam logic [HW-1:0] LAST = HW'(N - 1);

    bam_state_t     state;
    bam_state_t     nxt;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [VW-1:0]  v_q;
    logic [HW-1:0]  r;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] row;
    logic [2*N-1:0] p_q;
    logic           vld_q;
    logic           rdy;
    logic           accept;
    logic           skip;
    logic           last;
    logic           b_bit;

    assign accept = bus.in_valid && rdy;
    assign skip   = bus.h >= N_H;
    assign last   = r == LAST;

    always_comb begin
        b_bit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r == HW'(i)) b_bit = b_q[i];
        end
    end

    bam_row_gen #(
        .N (N),
        .HW(HW),
        .VW(VW)
    ) u_row (
        .a    (a_q),
        .b_bit(b_bit),
        .r    (r),
        .v    (v_q),
        .row  (row)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (accept) nxt = skip ? DONE : RUN;
            RUN:     if (last) nxt = DONE;
            DONE:    if (vld_q && bus.out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        rdy = (state == IDLE);
    end

    // The first DONE cycle registers the finished sum into the output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            v_q   <= '0;
            r     <= '0;
            acc   <= '0;
            p_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q <= bus.a;
                b_q <= bus.b;
                v_q <= bus.v;
                r   <= bus.h;
                acc <= '0;
            end else if (state == RUN) begin
                acc <= acc + row;
                r   <= r + HW'(1);
            end
            if (state == DONE) begin
                if (!vld_q) begin
                    vld_q <= 1'b1;
                    p_q   <= acc;
                end else if (bus.out_ready) begin
                    vld_q <= 1'b0;
                end
            end else begin
                vld_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld_q;
    assign bus.out_p     = p_q;

endmodule

// File: tb/tb_u_seq_bam.sv
// Self-checking bench for u_seq_bam at N=4, 8 and 12 with a result scoreboard.
module tb_u_seq_bam;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        iv = 1'b0;
    logic [11:0] da = '0;
    logic [11:0] db = '0;
    logic [3:0]  dh = '0;
    logic [4:0]  dv = '0;
    logic        ordy = 1'b1;
    int          sel = 8;

    logic        mir;
    logic        mov;
    logic [23:0] mp;

    int n_tests = 0;
    int n_fail = 0;
    logic [23:0] exp_q[$];

    u_seq_bam_if #(.N(4))  if4 ();
    u_seq_bam_if #(.N(8))  if8 ();
    u_seq_bam_if #(.N(12)) if12 ();

    u_seq_bam #(.N(4))  d4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    u_seq_bam #(.N(8))  d8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    u_seq_bam #(.N(12)) d12 (.clk(clk), .rst_n(rst_n), .bus(if12));

    assign if4.in_valid  = iv && (sel == 4);
    assign if4.a         = da[3:0];
    assign if4.b         = db[3:0];
    assign if4.h         = dh[2:0];
    assign if4.v         = dv[3:0];
    assign if4.out_ready = ordy;

    assign if8.in_valid  = iv && (sel == 8);
    assign if8.a         = da[7:0];
    assign if8.b         = db[7:0];
    assign if8.h         = dh;
    assign if8.v         = dv;
    assign if8.out_ready = ordy;

    assign if12.in_valid  = iv && (sel == 12);
    assign if12.a         = da;
    assign if12.b         = db;
    assign if12.h         = dh;
    assign if12.v         = dv;
    assign if12.out_ready = ordy;

    always_comb begin
        mir = if8.in_ready;
        mov = if8.out_valid;
        mp  = 24'(if8.out_p);
        if (sel == 4) begin
            mir = if4.in_ready;
            mov = if4.out_valid;
            mp  = 24'(if4.out_p);
        end else if (sel == 12) begin
            mir = if12.in_ready;
            mov = if12.out_valid;
            mp  = 24'(if12.out_p);
        end
    end

    function automatic logic [23:0] ref_bam(input int n, input int a, input int b,
                                            input int h, input int v);
        logic [23:0] s;
        s = '0;
        for (int i = h; i < n; i++)
            for (int j = 0; j < n; j++)
                if ((i + j) >= v && a[j] && b[i]) s = s + (24'(1) << (i + j));
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic sb_check(input string name);
        logic [23:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got %0d, expected no result", name, mp);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'(mp), 32'(e));
        end
    endtask

    // Full operation with out_ready high; latency counted in edges from accept.
    task automatic run_op(input int n, input int a, input int b, input int h, input int v,
                          input logic [23:0] p, input int lat_req, input string tag);
        int cnt;
        @(negedge clk);
        sel = n;
        ordy = 1'b1;
        #1;
        cnt = 0;
        while (!mir && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (!mir) check({tag, "_ready_wait"}, 32'(mir), 1);
        iv = 1'b1;
        da = 12'(a);
        db = 12'(b);
        dh = 4'(h);
        dv = 5'(v);
        @(posedge clk);
        exp_q.push_back(p);
        @(negedge clk);
        iv = 1'b0;
        da = 12'($urandom);
        db = 12'($urandom);
        dh = 4'($urandom);
        dv = 5'($urandom);
        cnt = 0;
        while (!mov && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_lat"}, 32'(cnt), 32'(lat_req));
        if (mov) sb_check({tag, "_p"});
    endtask

    typedef struct {
        int a;
        int b;
        int h;
        int v;
        int p;
        int lat;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int a;
        int b;
        int hmax;
        int vmax;
        logic [23:0] e;

        tbl[0]  = '{255, 255, 0, 0, 65025, 9};
        tbl[1]  = '{255, 255, 5, 12, 45056, 4};
        tbl[2]  = '{200, 100, 8, 0, 0, 1};
        tbl[3]  = '{3, 5, 0, 0, 15, 9};
        tbl[4]  = '{170, 85, 0, 0, 14450, 9};
        tbl[5]  = '{255, 255, 0, 14, 16384, 9};
        tbl[6]  = '{255, 255, 0, 15, 0, 9};
        tbl[7]  = '{1, 128, 7, 0, 128, 2};
        tbl[8]  = '{255, 255, 7, 0, 32640, 2};
        tbl[9]  = '{255, 255, 15, 0, 0, 1};
        tbl[10] = '{255, 255, 0, 31, 0, 9};
        tbl[11] = '{129, 129, 0, 8, 16384, 9};

        repeat (3) @(negedge clk);
        check("rst_in_ready8", 32'(if8.in_ready), 1);
        check("rst_out_valid8", 32'(if8.out_valid), 0);
        check("rst_out_p8", 32'(if8.out_p), 0);
        check("rst_in_ready4", 32'(if4.in_ready), 1);
        check("rst_out_valid12", 32'(if12.out_valid), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_op(8, tbl[i].a, tbl[i].b, tbl[i].h, tbl[i].v, 24'(tbl[i].p),
                   tbl[i].lat, $sformatf("tbl%0d", i));

        // h >= N: in_ready low for the DONE cycle and the return.
        @(negedge clk);
        sel = 8;
        ordy = 1'b1;
        iv = 1'b1;
        da = 12'd200;
        db = 12'd100;
        dh = 4'd8;
        dv = 5'd0;
        @(posedge clk);
        exp_q.push_back(24'd0);
        @(negedge clk);
        iv = 1'b0;
        cnt = 0;
        while (!mir && cnt < 20) begin
            cnt++;
            if (mov) sb_check("skip_p");
            @(negedge clk);
        end
        check("skip_ready_low", 32'(cnt), 2);

        // Back-pressure with a competing request held during DONE.
        @(negedge clk);
        sel = 8;
        ordy = 1'b0;
        iv = 1'b1;
        da = 12'd123;
        db = 12'd45;
        dh = 4'd2;
        dv = 5'd3;
        @(posedge clk);
        exp_q.push_back(ref_bam(8, 123, 45, 2, 3));
        e = ref_bam(8, 123, 45, 2, 3);
        @(negedge clk);
        da = 12'd77;
        db = 12'd99;
        dh = 4'd0;
        dv = 5'd0;
        cnt = 0;
        while (!mov && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("bp_lat", 32'(cnt), 7);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid%0d", i), 32'(mov), 1);
            check($sformatf("bp_p%0d", i), 32'(mp), 32'(e));
            check($sformatf("bp_ready%0d", i), 32'(mir), 0);
            @(negedge clk);
        end
        sb_check("bp_result");
        ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_ready", 32'(mir), 1);
        check("bp_release_valid", 32'(mov), 0);
        @(posedge clk);
        exp_q.push_back(ref_bam(8, 77, 99, 0, 0));
        @(negedge clk);
        iv = 1'b0;
        cnt = 0;
        while (!mov && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_lat", 32'(cnt), 9);
        if (mov) sb_check("b2b_p");

        // Reset in the third cycle of an h=0 operation.
        @(negedge clk);
        sel = 8;
        iv = 1'b1;
        da = 12'd255;
        db = 12'd255;
        dh = 4'd0;
        dv = 5'd0;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 32'(mir), 1);
        check("mid_rst_valid", 32'(mov), 0);
        check("mid_rst_p", 32'(mp), 0);
        rst_n = 1'b1;
        run_op(8, 3, 5, 0, 0, 24'd15, 9, "post_rst");

        // Sweep every (h, v) encoding with random operands.
        for (int k = 0; k < 2; k++) begin
            automatic int n = (k == 0) ? 4 : 12;
            hmax = (n == 4) ? 7 : 15;
            vmax = (n == 4) ? 15 : 31;
            for (int h = 0; h <= hmax; h++) begin
                for (int v = 0; v <= vmax; v++) begin
                    a = int'($urandom_range(0, (1 << n) - 1));
                    b = int'($urandom_range(0, (1 << n) - 1));
                    run_op(n, a, b, h, v, ref_bam(n, a, b, h, v),
                           (h >= n) ? 1 : n - h + 1,
                           $sformatf("sw%0d_h%0d_v%0d", n, h, v));
                end
            end
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 0);
        check("idle_valid", 32'(mov), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
